// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus CPU datapath.
//
// All architectural registers (R1-R15, PC, IR, MAR, MDR, HI, LO, Y and the
// 64-bit Z) share one bus. An external control unit sequences microsteps by
// raising out/in strobes, one microstep per rising clock edge.
//
// Ports:
//   Clock              system clock, all state updates on the rising edge
//   Clear              asynchronous active-low reset of every register
//   PCout .. R4out     bus-source selects (priority R4 > R2 > MDR > Zlo > Zhi > PC)
//   MARin .. Yin       load enables from the bus (MDR source chosen by Read)
//   R1in .. R15in      general register load enables from the bus
//   HIin, LOin         HI/LO load enables from the bus
//   ZHighIn, ZLowIn    load Z[63:32] / Z[31:0] from the ALU result
//   IncPC              ALU override: result = bus + 1
//   Read               MDR input select: 1 = Mdatain, 0 = bus
//   AND                5-bit ALU operation code
//   Cin                carry-in for ADD
//   Mdatain            memory read data
//   BusMuxOut          current bus value (combinational)
module cpu_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  // Bus-source selects
  input  logic             PCout,
  input  logic             ZHighout,
  input  logic             Zlowout,
  input  logic             MDRout,
  input  logic             R2out,
  input  logic             R4out,
  // Special-register load enables
  input  logic             MARin,
  input  logic             PCin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  // General-register load enables
  input  logic             R1in,
  input  logic             R2in,
  input  logic             R3in,
  input  logic             R4in,
  input  logic             R5in,
  input  logic             R6in,
  input  logic             R7in,
  input  logic             R8in,
  input  logic             R9in,
  input  logic             R10in,
  input  logic             R11in,
  input  logic             R12in,
  input  logic             R13in,
  input  logic             R14in,
  input  logic             R15in,
  input  logic             HIin,
  input  logic             LOin,
  // ALU result capture and control
  input  logic             ZHighIn,
  input  logic             ZLowIn,
  input  logic             IncPC,
  input  logic             Read,
  input  logic [4:0]       AND,
  input  logic             Cin,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] BusMuxOut
);

  localparam int unsigned ShW = $clog2(WIDTH);
  localparam logic [ShW:0] WidthAmt = (ShW + 1)'(WIDTH);

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpShr  = 5'b00101;
  localparam logic [4:0] OpShra = 5'b00110;
  localparam logic [4:0] OpShl  = 5'b00111;
  localparam logic [4:0] OpRor  = 5'b01000;
  localparam logic [4:0] OpAnd  = 5'b01001;
  localparam logic [4:0] OpOr   = 5'b01010;
  localparam logic [4:0] OpRol  = 5'b01011;
  localparam logic [4:0] OpMul  = 5'b01100;
  localparam logic [4:0] OpDiv  = 5'b01101;
  localparam logic [4:0] OpNeg  = 5'b01110;
  localparam logic [4:0] OpNot  = 5'b01111;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // R0 is architecturally constant zero and never drives the bus, so it has
  // no storage at all; the file starts at R1.
  logic [WIDTH-1:0]   r_q [1:15];
  logic [WIDTH-1:0]   r_d [1:15];
  logic [15:1]        r_in;

  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   ir_q, ir_d;
  logic [WIDTH-1:0]   mar_q, mar_d;
  logic [WIDTH-1:0]   mdr_q, mdr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in};

  // ---------------------------------------------------------------------------
  // Bus multiplexer
  // ---------------------------------------------------------------------------
  always_comb begin
    BusMuxOut = '0;
    if (R4out) begin
      BusMuxOut = r_q[4];
    end else if (R2out) begin
      BusMuxOut = r_q[2];
    end else if (MDRout) begin
      BusMuxOut = mdr_q;
    end else if (Zlowout) begin
      BusMuxOut = z_q[WIDTH-1:0];
    end else if (ZHighout) begin
      BusMuxOut = z_q[2*WIDTH-1:WIDTH];
    end else if (PCout) begin
      BusMuxOut = pc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU: A = Y, B = bus, 64-bit result
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [ShW-1:0]     sh_amt;
  logic [ShW:0]       sh_inv;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   sra_res;
  logic [WIDTH-1:0]   ror_res, rol_res;
  logic [2*WIDTH-1:0] a_sext, b_sext, mul_prod;
  logic               div_by_zero;
  logic [WIDTH-1:0]   div_den, div_q, div_r;
  logic [2*WIDTH-1:0] alu_c;

  assign alu_a  = y_q;
  assign alu_b  = BusMuxOut;
  assign sh_amt = alu_b[ShW-1:0];
  // Complementary shift for rotates; a shift by the full width yields zero, so
  // a rotate by 0 degenerates cleanly to A.
  assign sh_inv = WidthAmt - {1'b0, sh_amt};

  assign add_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, Cin};
  assign sra_res = $signed(alu_a) >>> sh_amt;
  assign ror_res = (alu_a >> sh_amt) | (alu_a << sh_inv);
  assign rol_res = (alu_a << sh_amt) | (alu_a >> sh_inv);

  // Low 2*WIDTH bits of the product of sign-extended operands equal the full
  // signed product.
  assign a_sext   = {{WIDTH{alu_a[WIDTH-1]}}, alu_a};
  assign b_sext   = {{WIDTH{alu_b[WIDTH-1]}}, alu_b};
  assign mul_prod = a_sext * b_sext;

  // Divisor forced non-zero so the divider never sees 0; the result is
  // discarded in that case anyway.
  assign div_by_zero = (alu_b == '0);
  assign div_den     = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : alu_b;
  assign div_q       = $signed(alu_a) / $signed(div_den);
  assign div_r       = $signed(alu_a) % $signed(div_den);

  always_comb begin
    alu_c = '0;
    if (IncPC) begin
      alu_c = {{WIDTH{1'b0}}, alu_b + WIDTH'(1)};
    end else begin
      case (AND)
        OpAdd:   alu_c = {{(WIDTH-1){1'b0}}, add_sum};
        OpSub:   alu_c = {{WIDTH{1'b0}}, alu_a - alu_b};
        OpShr:   alu_c = {{WIDTH{1'b0}}, alu_a >> sh_amt};
        OpShra:  alu_c = {{WIDTH{1'b0}}, sra_res};
        OpShl:   alu_c = {{WIDTH{1'b0}}, alu_a << sh_amt};
        OpRor:   alu_c = {{WIDTH{1'b0}}, ror_res};
        OpRol:   alu_c = {{WIDTH{1'b0}}, rol_res};
        OpAnd:   alu_c = {{WIDTH{1'b0}}, alu_a & alu_b};
        OpOr:    alu_c = {{WIDTH{1'b0}}, alu_a | alu_b};
        OpMul:   alu_c = mul_prod;
        OpDiv:   alu_c = div_by_zero ? '0 : {div_r, div_q};
        OpNeg:   alu_c = {{WIDTH{1'b0}}, '0 - alu_b};
        OpNot:   alu_c = {{WIDTH{1'b0}}, ~alu_b};
        default: alu_c = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: every register loads the pre-edge bus value
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d  = PCin  ? BusMuxOut : pc_q;
    ir_d  = IRin  ? BusMuxOut : ir_q;
    mar_d = MARin ? BusMuxOut : mar_q;
    hi_d  = HIin  ? BusMuxOut : hi_q;
    lo_d  = LOin  ? BusMuxOut : lo_q;
    y_d   = Yin   ? BusMuxOut : y_q;

    mdr_d = mdr_q;
    if (MDRin) begin
      mdr_d = Read ? Mdatain : BusMuxOut;
    end

    z_d = z_q;
    if (ZHighIn) begin
      z_d[2*WIDTH-1:WIDTH] = alu_c[2*WIDTH-1:WIDTH];
    end
    if (ZLowIn) begin
      z_d[WIDTH-1:0] = alu_c[WIDTH-1:0];
    end

    for (int i = 1; i <= 15; i++) begin
      r_d[i] = r_in[i] ? BusMuxOut : r_q[i];
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      z_q   <= '0;
      for (int i = 1; i <= 15; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      y_q   <= y_d;
      z_q   <= z_d;
      for (int i = 1; i <= 15; i++) begin
        r_q[i] <= r_d[i];
      end
    end
  end

  // Registers without a bus-out path are only observed hierarchically; this
  // reduction marks them as intentionally unread inside the block.
  logic unused_state;
  always_comb begin
    unused_state = ^{mar_q, ir_q, hi_q, lo_q};
    for (int i = 1; i <= 15; i++) begin
      unused_state = unused_state ^ (^r_q[i]);
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Testbench for cpu_datapath: directed microstep sequences, a behavioural model
// compared against the DUT on every falling edge, and literal spot checks.
module tb_cpu_datapath;

  logic        Clock, Clear;
  logic        PCout, ZHighout, Zlowout, MDRout, R2out, R4out;
  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic        ZHighIn, ZLowIn, IncPC, Read, Cin;
  logic [15:1] rin;
  logic [4:0]  op;
  logic [31:0] Mdatain, BusMuxOut;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  cpu_datapath #(.WIDTH(32)) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .PCout    (PCout),
    .ZHighout (ZHighout),
    .Zlowout  (Zlowout),
    .MDRout   (MDRout),
    .R2out    (R2out),
    .R4out    (R4out),
    .MARin    (MARin),
    .PCin     (PCin),
    .MDRin    (MDRin),
    .IRin     (IRin),
    .Yin      (Yin),
    .R1in     (rin[1]),
    .R2in     (rin[2]),
    .R3in     (rin[3]),
    .R4in     (rin[4]),
    .R5in     (rin[5]),
    .R6in     (rin[6]),
    .R7in     (rin[7]),
    .R8in     (rin[8]),
    .R9in     (rin[9]),
    .R10in    (rin[10]),
    .R11in    (rin[11]),
    .R12in    (rin[12]),
    .R13in    (rin[13]),
    .R14in    (rin[14]),
    .R15in    (rin[15]),
    .HIin     (HIin),
    .LOin     (LOin),
    .ZHighIn  (ZHighIn),
    .ZLowIn   (ZLowIn),
    .IncPC    (IncPC),
    .Read     (Read),
    .AND      (op),
    .Cin      (Cin),
    .Mdatain  (Mdatain),
    .BusMuxOut(BusMuxOut)
  );

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y;
  logic [63:0] m_z;
  logic [31:0] mb;
  logic [63:0] mc;

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_hi = 0; m_lo = 0; m_y = 0; m_z = 0;
  endtask

  function automatic logic [31:0] m_bus();
    if (R4out)    return m_r[4];
    if (R2out)    return m_r[2];
    if (MDRout)   return m_mdr;
    if (Zlowout)  return m_z[31:0];
    if (ZHighout) return m_z[63:32];
    if (PCout)    return m_pc;
    return 32'h0;
  endfunction

  function automatic logic [63:0] m_alu(input logic [4:0] f, input logic [31:0] a,
                                        input logic [31:0] b, input logic ci,
                                        input logic inc);
    int          sh;
    int          sa;
    logic [31:0] t;
    longint      p;
    sh = int'(b % 32);
    if (inc) return {32'h0, b + 32'd1};
    case (f)
      5'b00011: return 64'(a) + 64'(b) + 64'(ci);
      5'b00100: begin t = a - b; return {32'h0, t}; end
      5'b00101: return {32'h0, a >> sh};
      5'b00110: begin sa = int'(a); sa = sa >>> sh; return {32'h0, 32'(sa)}; end
      5'b00111: return {32'h0, a << sh};
      5'b01000: begin t = a; repeat (sh) t = {t[0], t[31:1]}; return {32'h0, t}; end
      5'b01011: begin t = a; repeat (sh) t = {t[30:0], t[31]}; return {32'h0, t}; end
      5'b01001: return {32'h0, a & b};
      5'b01010: return {32'h0, a | b};
      5'b01100: begin p = longint'(int'(a)) * longint'(int'(b)); return 64'(p); end
      5'b01101: begin
        if (b == 0) return 64'h0;
        return {32'(int'(a) % int'(b)), 32'(int'(a) / int'(b))};
      end
      5'b01110: begin t = 32'h0 - b; return {32'h0, t}; end
      5'b01111: return {32'h0, ~b};
      default:  return 64'h0;
    endcase
  endfunction

  always @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      m_reset();
    end else begin
      mb = m_bus();
      mc = m_alu(op, m_y, mb, Cin, IncPC);
      if (PCin)  m_pc  = mb;
      if (IRin)  m_ir  = mb;
      if (MARin) m_mar = mb;
      if (HIin)  m_hi  = mb;
      if (LOin)  m_lo  = mb;
      if (Yin)   m_y   = mb;
      if (MDRin) m_mdr = Read ? Mdatain : mb;
      if (ZHighIn) m_z[63:32] = mc[63:32];
      if (ZLowIn)  m_z[31:0]  = mc[31:0];
      for (int i = 1; i < 16; i++) if (rin[i]) m_r[i] = mb;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      check("model bus", BusMuxOut, m_bus());
      check("model pc", dut.pc_q, m_pc);
      check("model ir", dut.ir_q, m_ir);
      check("model mar", dut.mar_q, m_mar);
      check("model mdr", dut.mdr_q, m_mdr);
      check("model hi", dut.hi_q, m_hi);
      check("model lo", dut.lo_q, m_lo);
      check("model y", dut.y_q, m_y);
      check("model z", dut.z_q, m_z);
      for (int i = 1; i < 16; i++) check($sformatf("model r%0d", i), dut.r_q[i], m_r[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle();
    PCout = 0; ZHighout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R4out = 0;
    MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; HIin = 0; LOin = 0;
    ZHighIn = 0; ZLowIn = 0; IncPC = 0; Read = 0; Cin = 0;
    rin = '0; op = 5'b0; Mdatain = 32'h0;
  endtask

  // Returns 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_reg(input int k, input logic [31:0] v);
    idle(); Read = 1; MDRin = 1; Mdatain = v; tick();
    idle(); MDRout = 1; rin[k] = 1; tick();
    idle();
  endtask

  task automatic alu_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] f, input logic ci, input logic inc,
                         input logic [63:0] exp);
    idle(); Read = 1; MDRin = 1; Mdatain = a; tick();
    idle(); MDRout = 1; Yin = 1; tick();
    idle(); Read = 1; MDRin = 1; Mdatain = b; tick();
    idle(); MDRout = 1; op = f; Cin = ci; IncPC = inc; ZHighIn = 1; ZLowIn = 1; tick();
    check(name, dut.z_q, exp);
    idle();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    Clear = 1;
    idle();
    m_reset();
    #2 Clear = 0;
    #1;
    check("reset bus", BusMuxOut, 32'h0);
    check("reset pc", dut.pc_q, 32'h0);
    check("reset z", dut.z_q, 64'h0);
    tick();
    Clear = 1;
    chk_en = 1;

    // Register loads through MDR
    load_reg(2, 32'h22);
    check("load r2", dut.r_q[2], 32'h22);
    load_reg(4, 32'h24);
    check("load r4", dut.r_q[4], 32'h24);
    load_reg(5, 32'h26);
    check("load r5", dut.r_q[5], 32'h26);
    tick(); tick();
    check("hold r2", dut.r_q[2], 32'h22);

    // Fetch from PC = 0
    idle(); PCout = 1; MARin = 1; IncPC = 1; ZLowIn = 1; tick();
    check("T0 mar", dut.mar_q, 32'h0);
    check("T0 zlow", dut.z_q[31:0], 32'h1);
    idle(); Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h4A92_0000; tick();
    check("T1 pc", dut.pc_q, 32'h1);
    check("T1 mdr", dut.mdr_q, 32'h4A92_0000);
    idle(); MDRout = 1; IRin = 1; tick();
    check("T2 ir", dut.ir_q, 32'h4A92_0000);

    // and R5,R2,R4
    idle(); R2out = 1; Yin = 1; tick();
    check("T3 y", dut.y_q, 32'h22);
    idle(); R4out = 1; op = 5'b01001; ZLowIn = 1; tick();
    check("T4 zlow", dut.z_q[31:0], 32'h20);
    idle(); Zlowout = 1; rin[5] = 1; tick();
    check("T5 r5", dut.r_q[5], 32'h20);
    check("T5 bus", BusMuxOut, 32'h20);

    // Bus priority
    idle(); R2out = 1; R4out = 1; #1;
    check("prio r4>r2", BusMuxOut, 32'h24);
    R4out = 0; MDRout = 1; #1;
    check("prio r2>mdr", BusMuxOut, 32'h22);
    idle(); ZHighout = 1; PCout = 1; #1;
    check("prio zhi>pc", BusMuxOut, 32'h0);
    idle(); PCout = 1; #1;
    check("bus pc", BusMuxOut, 32'h1);
    idle(); #1;
    check("bus none", BusMuxOut, 32'h0);
    tick();

    // Z drives the bus and reloads from it in the same step
    idle(); Zlowout = 1; IncPC = 1; ZLowIn = 1; tick();
    check("self inc zlow", dut.z_q[31:0], 32'h21);

    // HI, LO, R1, R15 from MDR
    idle(); MDRout = 1; HIin = 1; rin[15] = 1; tick();
    check("hi load", dut.hi_q, 32'h4A92_0000);
    check("r15 load", dut.r_q[15], 32'h4A92_0000);
    idle(); R4out = 1; LOin = 1; rin[1] = 1; tick();
    check("lo load", dut.lo_q, 32'h24);
    check("r1 load", dut.r_q[1], 32'h24);

    // ALU sweep
    alu_vec("alu add cin", 32'hFFFF_FFFE, 32'h3, 5'b00011, 1, 0, 64'h1_0000_0002);
    alu_vec("alu mul", 32'hFFFF_FFFE, 32'h2, 5'b01100, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC);
    alu_vec("alu div0", 32'hFFFF_FFFE, 32'h0, 5'b01101, 0, 0, 64'h0);
    alu_vec("alu ror1", 32'hFFFF_FFFE, 32'h1, 5'b01000, 0, 0, 64'h7FFF_FFFF);
    alu_vec("alu div", 32'hFFFF_FFF9, 32'h2, 5'b01101, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD);
    alu_vec("alu sub", 32'hFFFF_FFFE, 32'h3, 5'b00100, 0, 0, 64'hFFFF_FFFB);
    alu_vec("alu shra", 32'h8000_0000, 32'h4, 5'b00110, 0, 0, 64'hF800_0000);
    alu_vec("alu shr", 32'h8000_0000, 32'h4, 5'b00101, 0, 0, 64'h0800_0000);
    alu_vec("alu shl0", 32'hFFFF_FFFE, 32'h0, 5'b00111, 0, 0, 64'hFFFF_FFFE);
    alu_vec("alu rol1", 32'h8000_0001, 32'h1, 5'b01011, 0, 0, 64'h3);
    alu_vec("alu neg", 32'h0, 32'h2, 5'b01110, 0, 0, 64'hFFFF_FFFE);
    alu_vec("alu not", 32'h0, 32'h0F0F_0F0F, 5'b01111, 0, 0, 64'hF0F0_F0F0);
    alu_vec("alu or", 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'b01010, 0, 0, 64'hFCFC_FCFC);
    alu_vec("alu bad op", 32'h1234_5678, 32'h1, 5'b00000, 0, 0, 64'h0);
    alu_vec("alu add carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00011, 0, 0, 64'h1_FFFF_FFFE);
    alu_vec("alu incpc wrap", 32'h5, 32'hFFFF_FFFF, 5'b00011, 1, 1, 64'h0);
    alu_vec("alu shl amt mod", 32'h1, 32'h21, 5'b00111, 0, 0, 64'h2);

    // Asynchronous reset mid-cycle
    load_reg(5, 32'h77);
    idle(); MDRout = 1;
    #2 Clear = 0;
    #1;
    check("midreset bus", BusMuxOut, 32'h0);
    check("midreset pc", dut.pc_q, 32'h0);
    check("midreset mdr", dut.mdr_q, 32'h0);
    check("midreset y", dut.y_q, 32'h0);
    check("midreset z", dut.z_q, 64'h0);
    check("midreset r5", dut.r_q[5], 32'h0);
    check("midreset ir", dut.ir_q, 32'h0);
    idle(); Read = 1; MDRin = 1; Mdatain = 32'h55; rin[5] = 1; tick();
    check("clear overrides mdr", dut.mdr_q, 32'h0);
    Clear = 1;
    idle(); tick();
    check("post clear mdr", dut.mdr_q, 32'h0);
    check("post clear bus", BusMuxOut, 32'h0);

    @(negedge Clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
